// File: rtl/fast_pkg.sv
// Shared types and constants for the FAST corner scheduling slice.
package fast_pkg;

  localparam int unsigned FAST_RADIUS = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROW,
    ISSUE,
    WAIT_FAST,
    EMIT,
    DONE
  } fast_sched_state_t;

  // Corner record handed to the orientation/descriptor stage.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  score;
  } corner_rec_t;

endpackage

// File: rtl/fast_row_credit.sv
// Counts filtered rows resident in the line buffer; saturates at HEIGHT.
module fast_row_credit #(
  parameter int unsigned HEIGHT = 400,
  parameter int unsigned R_W    = $clog2(HEIGHT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           load_val,
  input  logic           inc,
  output logic [R_W-1:0] rows_rcvd
);

  // Load on frame arm, otherwise count row arrivals up to HEIGHT.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_rcvd <= '0;
    end else if (load) begin
      rows_rcvd <= R_W'(load_val);
    end else if (inc && (rows_rcvd < R_W'(HEIGHT))) begin
      rows_rcvd <= rows_rcvd + R_W'(1);
    end
  end

endmodule

// File: rtl/fast_pixel_scheduler.sv
// Walks one frame in raster order, issuing FAST evaluations once the 7-row
// window is resident and streaming corner records downstream.
module fast_pixel_scheduler
  import fast_pkg::*;
#(
  parameter int unsigned WIDTH  = 400,
  parameter int unsigned HEIGHT = 400,
  parameter int unsigned RADIUS = FAST_RADIUS,
  parameter int unsigned X_W    = $clog2(WIDTH),
  parameter int unsigned Y_W    = $clog2(HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_start,
  input  logic           row_ready,
  output logic           fast_start,
  output logic [X_W-1:0] fast_x,
  output logic [Y_W-1:0] fast_y,
  input  logic           fast_done,
  input  logic           fast_is_corner,
  input  logic [7:0]     fast_score,
  output logic           corner_valid,
  input  logic           corner_ready,
  output logic [X_W-1:0] corner_x,
  output logic [Y_W-1:0] corner_y,
  output logic [7:0]     corner_score,
  output logic           busy,
  output logic           frame_done,
  output logic [15:0]    corner_count
);

  localparam int unsigned R_W = $clog2(HEIGHT + 1);
  localparam logic [X_W-1:0] X_FIRST = X_W'(RADIUS);
  localparam logic [X_W-1:0] X_LAST  = X_W'(WIDTH - RADIUS - 1);
  localparam logic [Y_W-1:0] Y_FIRST = Y_W'(RADIUS);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(HEIGHT - RADIUS - 1);

  fast_sched_state_t state;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [R_W-1:0]    rows_rcvd;
  logic              row_avail;
  logic              advance;

  fast_row_credit #(
    .HEIGHT (HEIGHT),
    .R_W    (R_W)
  ) u_row_credit (
    .clk       (clk),
    .rst       (rst),
    .load      ((state == IDLE) && frame_start),
    .load_val  (row_ready),
    .inc       ((state != IDLE) && row_ready),
    .rows_rcvd (rows_rcvd)
  );

  assign row_avail = 32'(rows_rcvd) >= (32'(y) + RADIUS + 32'd1);
  assign advance   = ((state == WAIT_FAST) && fast_done && !fast_is_corner) ||
                     ((state == EMIT) && corner_ready);
  assign busy      = (state != IDLE);

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      fast_start   <= 1'b0;
      fast_x       <= '0;
      fast_y       <= '0;
      corner_valid <= 1'b0;
      corner_x     <= '0;
      corner_y     <= '0;
      corner_score <= '0;
      frame_done   <= 1'b0;
      corner_count <= '0;
    end else begin
      fast_start <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            x            <= X_FIRST;
            y            <= Y_FIRST;
            corner_count <= '0;
            state        <= WAIT_ROW;
          end
        end
        WAIT_ROW: begin
          if (row_avail) begin
            state      <= ISSUE;
            fast_start <= 1'b1;
            fast_x     <= x;
            fast_y     <= y;
          end
        end
        ISSUE: state <= WAIT_FAST;
        WAIT_FAST: begin
          if (fast_done && fast_is_corner) begin
            corner_valid <= 1'b1;
            corner_x     <= x;
            corner_y     <= y;
            corner_score <= fast_score;
            state        <= EMIT;
          end
        end
        EMIT: begin
          if (corner_ready) begin
            corner_valid <= 1'b0;
            if (corner_count != '1) corner_count <= corner_count + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Pixel advance is shared by WAIT_FAST and EMIT; these later
      // assignments take precedence over the per-state ones above.
      if (advance) begin
        if (x < X_LAST) begin
          x          <= x + X_W'(1);
          state      <= ISSUE;
          fast_start <= 1'b1;
          fast_x     <= x + X_W'(1);
          fast_y     <= y;
        end else if (y == Y_LAST) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end else begin
          x     <= X_FIRST;
          y     <= y + Y_W'(1);
          state <= WAIT_ROW;
        end
      end
    end
  end

endmodule

// File: tb/tb_fast_pixel_scheduler.sv
// Randomized bench for fast_pixel_scheduler: raster-order pixel/corner model,
// FAST responder and corner sink, plus directed edge cases.
module tb_fast_pixel_scheduler;
  import fast_pkg::*;

  localparam int unsigned W  = 10;
  localparam int unsigned H  = 8;
  localparam int unsigned R  = FAST_RADIUS;
  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          row_ready = 1'b0;
  logic          fast_start;
  logic [XW-1:0] fast_x;
  logic [YW-1:0] fast_y;
  logic          fast_done = 1'b0;
  logic          fast_is_corner = 1'b0;
  logic [7:0]    fast_score = '0;
  logic          corner_valid;
  logic          corner_ready = 1'b0;
  logic [XW-1:0] corner_x;
  logic [YW-1:0] corner_y;
  logic [7:0]    corner_score;
  logic          busy;
  logic          frame_done;
  logic [15:0]   corner_count;

  fast_pixel_scheduler #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .row_ready      (row_ready),
    .fast_start     (fast_start),
    .fast_x         (fast_x),
    .fast_y         (fast_y),
    .fast_done      (fast_done),
    .fast_is_corner (fast_is_corner),
    .fast_score     (fast_score),
    .corner_valid   (corner_valid),
    .corner_ready   (corner_ready),
    .corner_x       (corner_x),
    .corner_y       (corner_y),
    .corner_score   (corner_score),
    .busy           (busy),
    .frame_done     (frame_done),
    .corner_count   (corner_count)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-frame corner map and the raster-ordered expectations.
  typedef struct {
    int unsigned x;
    int unsigned y;
  } pix_t;

  bit          corner_map [W][H];
  bit [7:0]    score_map  [W][H];
  pix_t        exp_pix[$];
  corner_rec_t exp_cor[$];
  int unsigned n_exp_cor = 0;
  int unsigned rows_sup  = 0;
  int unsigned fs_seen   = 0;
  int unsigned fd_seen   = 0;

  // Responder / sink knobs.
  bit          in_reset   = 1'b1;
  bit          spur_idle  = 1'b0;
  bit          spur_issue = 1'b0;
  bit          lat_rand   = 1'b0;
  int unsigned lat        = 3;
  int unsigned hold_n     = 0;
  int unsigned ready_pct  = 100;

  task automatic randomize_map(input int unsigned pct);
    for (int unsigned xi = 0; xi < W; xi++)
      for (int unsigned yi = 0; yi < H; yi++) begin
        corner_map[xi][yi] = ($urandom_range(0, 99) < pct);
        score_map[xi][yi]  = 8'($urandom);
      end
  endtask

  task automatic build_expect();
    corner_rec_t c;
    exp_pix.delete();
    exp_cor.delete();
    for (int unsigned yi = R; yi < H - R; yi++)
      for (int unsigned xi = R; xi < W - R; xi++) begin
        exp_pix.push_back('{x: xi, y: yi});
        if (corner_map[xi][yi]) begin
          c.x     = 16'(xi);
          c.y     = 16'(yi);
          c.score = score_map[xi][yi];
          exp_cor.push_back(c);
        end
      end
    n_exp_cor = exp_cor.size();
    rows_sup  = 0;
    fs_seen   = 0;
  endtask

  // FAST responder, corner sink and output monitor, all on the falling edge.
  initial begin
    pix_t        p;
    int unsigned pend;
    int unsigned cur_x, cur_y, valid_age;
    bit          prev_fs, r;
    pend = 0; cur_x = 0; cur_y = 0; valid_age = 0; prev_fs = 0;
    forever begin
      @(negedge clk);
      fast_done      = 1'b0;
      fast_is_corner = 1'b0;
      fast_score     = '0;
      if (in_reset) begin
        pend = 0; prev_fs = 0; valid_age = 0; corner_ready = 1'b0;
        continue;
      end
      if (fast_start) begin
        expect_eq("fs_single", 32'(prev_fs), 0);
        expect_eq("fs_rows_ok", 32'(rows_sup >= 32'(fast_y) + R + 1), 1);
        if (exp_pix.size() == 0) begin
          expect_eq("fs_unexpected", 1, 0);
        end else begin
          p = exp_pix.pop_front();
          expect_eq("fs_x", 32'(fast_x), p.x);
          expect_eq("fs_y", 32'(fast_y), p.y);
        end
        fs_seen++;
        pend  = lat_rand ? $urandom_range(1, 4) : lat;
        cur_x = 32'(fast_x);
        cur_y = 32'(fast_y);
        if (spur_issue) begin
          fast_done = 1'b1; fast_is_corner = 1'b1; fast_score = 8'hEE;
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fast_done      = 1'b1;
          fast_is_corner = corner_map[cur_x][cur_y];
          fast_score     = score_map[cur_x][cur_y];
        end
      end else if (spur_idle && !corner_valid) begin
        fast_done = 1'b1; fast_is_corner = 1'b1; fast_score = 8'hDD;
      end

      if (corner_valid) begin
        if (exp_cor.size() == 0) begin
          expect_eq("cv_unexpected", 1, 0);
        end else begin
          expect_eq("cv_x", 32'(corner_x), 32'(exp_cor[0].x));
          expect_eq("cv_y", 32'(corner_y), 32'(exp_cor[0].y));
          expect_eq("cv_score", 32'(corner_score), 32'(exp_cor[0].score));
        end
        expect_eq("cv_no_fs", 32'(fast_start), 0);
        r = (valid_age >= hold_n) && ($urandom_range(0, 99) < ready_pct);
        corner_ready = r;
        valid_age++;
        if (r) begin
          if (exp_cor.size() != 0) void'(exp_cor.pop_front());
          valid_age = 0;
        end
      end else begin
        corner_ready = 1'($urandom_range(0, 1));
        valid_age = 0;
      end

      if (frame_done) begin
        fd_seen++;
        expect_eq("fd_pix_left", exp_pix.size(), 0);
        expect_eq("fd_cor_left", exp_cor.size(), 0);
        expect_eq("fd_count", 32'(corner_count), n_exp_cor);
        expect_eq("fd_busy", 32'(busy), 1);
      end
      prev_fs = fast_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    expect_eq({tag, "_fs"},    32'(fast_start), 0);
    expect_eq({tag, "_fx"},    32'(fast_x), 0);
    expect_eq({tag, "_fy"},    32'(fast_y), 0);
    expect_eq({tag, "_cv"},    32'(corner_valid), 0);
    expect_eq({tag, "_cx"},    32'(corner_x), 0);
    expect_eq({tag, "_cy"},    32'(corner_y), 0);
    expect_eq({tag, "_cs"},    32'(corner_score), 0);
    expect_eq({tag, "_busy"},  32'(busy), 0);
    expect_eq({tag, "_fd"},    32'(frame_done), 0);
    expect_eq({tag, "_count"}, 32'(corner_count), 0);
  endtask

  task automatic start_frame(input bit with_row);
    frame_start = 1'b1;
    row_ready   = with_row;
    tick();
    if (with_row) rows_sup = 1;
    frame_start = 1'b0;
    row_ready   = 1'b0;
  endtask

  task automatic pulse_row();
    row_ready = 1'b1;
    tick();
    rows_sup++;
    row_ready = 1'b0;
  endtask

  task automatic deliver_rows(input int unsigned n, input int unsigned max_gap);
    for (int unsigned i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) tick();
      pulse_row();
    end
  endtask

  task automatic wait_fs(input int unsigned target, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (fs_seen < target && k < budget) begin tick(); k++; end
    if (fs_seen < target) expect_eq("fs_timeout", 0, 1);
  endtask

  task automatic finish_frame(input string tag);
    int unsigned fd0, k;
    fd0 = fd_seen;
    k   = 0;
    while (fd_seen == fd0 && k < 3000) begin tick(); k++; end
    expect_eq({tag, "_done_seen"}, fd_seen - fd0, 1);
    tick(); tick();
    expect_eq({tag, "_idle"}, 32'(busy), 0);
    expect_eq({tag, "_count_hold"}, 32'(corner_count), n_exp_cor);
    expect_eq({tag, "_fs_total"}, fs_seen, (W - 2 * R) * (H - 2 * R));
  endtask

  task automatic run_frame(input string tag, input int unsigned pct, input int unsigned gap);
    randomize_map(pct);
    build_expect();
    start_frame(1'($urandom_range(0, 1)));
    deliver_rows(H - rows_sup + $urandom_range(0, 2), gap);
    finish_frame(tag);
  endtask

  initial begin
    int unsigned fd0;
    // Reset state.
    tick(); tick();
    check_zero("reset");
    rst = 1'b0;
    in_reset = 1'b0;
    tick();

    // First row waits for the full window; then stalls in WAIT_ROW after row 3.
    lat = 3;
    randomize_map(0);
    build_expect();
    start_frame(1'b0);
    for (int unsigned i = 0; i < 6; i++) begin tick(); pulse_row(); end
    repeat (10) tick();
    expect_eq("t1_no_fs_early", fs_seen, 0);
    row_ready = 1'b1;
    tick();
    rows_sup++;
    row_ready = 1'b0;
    expect_eq("t1_fs_not_yet", 32'(fast_start), 0);
    tick();
    expect_eq("t1_fs", 32'(fast_start), 1);
    expect_eq("t1_fx", 32'(fast_x), R);
    expect_eq("t1_fy", 32'(fast_y), R);
    repeat (60) tick();
    expect_eq("t4_fs_row3", fs_seen, W - 2 * R);
    expect_eq("t4_pix_left", exp_pix.size(), W - 2 * R);
    expect_eq("t4_busy", 32'(busy), 1);
    pulse_row();
    finish_frame("t2");

    // Single corner at (5,3) held off by the sink for 4 cycles.
    randomize_map(0);
    corner_map[5][3] = 1'b1;
    score_map[5][3]  = 8'h42;
    build_expect();
    hold_n = 4;
    start_frame(1'b0);
    deliver_rows(H, 0);
    finish_frame("t3");
    hold_n = 0;

    // Reset while waiting on the FAST core; mid-frame frame_start is ignored.
    lat = 6;
    randomize_map(30);
    build_expect();
    start_frame(1'b0);
    deliver_rows(3, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    deliver_rows(4, 1);
    wait_fs(1, 200);
    tick(); tick();
    fd0 = fd_seen;
    in_reset = 1'b1;
    rst = 1'b1;
    tick();
    check_zero("t5_rst");
    rst = 1'b0;
    tick();
    expect_eq("t5_no_fd", fd_seen, fd0);
    in_reset = 1'b0;
    lat = 3;
    run_frame("t5_restart", 30, 2);

    // Spurious fast_done in WAIT_ROW and ISSUE must be ignored.
    spur_idle  = 1'b1;
    spur_issue = 1'b1;
    randomize_map(40);
    build_expect();
    start_frame(1'b0);
    deliver_rows(H, 8);
    finish_frame("t6");
    spur_idle  = 1'b0;
    spur_issue = 1'b0;

    // Randomized frames.
    lat_rand = 1'b1;
    for (int unsigned f = 0; f < 8; f++) begin
      hold_n    = $urandom_range(0, 3);
      ready_pct = $urandom_range(50, 100);
      run_frame("rand", $urandom_range(0, 100), $urandom_range(0, 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fast_pixel_scheduler.md
Name: fast_pixel_scheduler

Overview:
Sequences the FAST corner core across one frame, pixel by pixel, in raster order. It tracks how many Gaussian-filtered rows are in the line buffer, issues one FAST evaluation per valid pixel once the full 7-row window is resident, and collects each result. Corners are emitted as (x, y, score) on a valid/ready stream to the orientation/descriptor stage. It sits between the Gaussian stage, the FAST core and the downstream corner FIFO.

Parameters:
WIDTH, 400, pixels per row
HEIGHT, 400, rows per frame
RADIUS, 3, FAST circle radius; border pixels closer than RADIUS to any edge are never evaluated
X_W, $clog2(WIDTH), column coordinate width (derived)
Y_W, $clog2(HEIGHT), row coordinate width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_start  in  1  pulse; arms a new frame
row_ready  in  1  pulse; one more filtered row is written to the line buffer
fast_start  out  1  one-cycle pulse; FAST core evaluates (fast_x, fast_y)
fast_x  out  X_W  column under test
fast_y  out  Y_W  row under test
fast_done  in  1  pulse; FAST result valid, always at least 1 cycle after fast_start
fast_is_corner  in  1  result flag, qualified by fast_done
fast_score  in  8  corner score, qualified by fast_done
corner_valid  out  1  corner record valid
corner_ready  in  1  downstream accepts
corner_x  out  X_W  corner column
corner_y  out  Y_W  corner row
corner_score  out  8  corner score
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at end of frame
corner_count  out  16  corners emitted this frame, saturating

Behaviour:
- One clock, clk. rst is synchronous and active-high. On rst: state IDLE; all outputs 0; rows_rcvd, x, y and corner_count cleared. Reset mid-frame abandons the frame without emitting frame_done.
- rows_rcvd: increments on row_ready in every non-IDLE state and saturates at HEIGHT. In IDLE, frame_start loads rows_rcvd with row_ready (0 or 1), sets x=RADIUS and y=RADIUS, clears corner_count, and moves to WAIT_ROW.
- frame_start outside IDLE is ignored.
- WAIT_ROW: when rows_rcvd >= y+RADIUS+1, go to ISSUE on the next cycle. The first row needs 2*RADIUS+1 = 7 rows.
- ISSUE: fast_start=1 for exactly one cycle with fast_x=x and fast_y=y; then go to WAIT_FAST. fast_x and fast_y hold until the next ISSUE.
- WAIT_FAST: on fast_done with fast_is_corner=1, latch x, y and score into the corner_* outputs and go to EMIT. On fast_done with fast_is_corner=0, ADVANCE. fast_done in any other state is ignored.
- EMIT: corner_valid held high with a stable payload until corner_ready. In the cycle of the handshake: corner_valid drops next cycle, corner_count increments (saturating at 0xFFFF), then ADVANCE.
- ADVANCE, performed in the same cycle as the transition:
  - If x < WIDTH-RADIUS-1: x++, go to ISSUE.
  - Otherwise, if y == HEIGHT-RADIUS-1: go to DONE.
  - Otherwise: x=RADIUS, y++, go to WAIT_ROW.
- DONE: frame_done=1 for one cycle, then IDLE. corner_count holds its value until the next frame_start.
- Throughput for a non-corner pixel: ISSUE, then FAST latency, then the next ISSUE. A corner adds at least 1 EMIT cycle.
- Pixels evaluated per frame: (WIDTH-2*RADIUS) x (HEIGHT-2*RADIUS).

Decomposition:
- Package fast_pkg holds:
  - the state enum fast_sched_state_t {IDLE, WAIT_ROW, ISSUE, WAIT_FAST, EMIT, DONE}
  - the FAST_RADIUS constant
  - the corner record struct (x, y, score)
- Sub-module fast_row_credit: the saturating rows_rcvd counter with load/clear. It exposes rows_rcvd to the scheduler FSM.

Test Plan:
WIDTH=10, HEIGHT=8 throughout.
1. frame_start, then 7 row_ready pulses -> the first fast_start comes only after the 7th pulse, at (3,3); no fast_start before it.
2. All results non-corner, 3-cycle FAST latency, 8 row_ready pulses -> 8 fast_start pulses at x=3..6 for y=3 and y=4; frame_done once; corner_count=0.
3. Corner at (5,3) with score 0x42, corner_ready held low for 4 cycles -> corner_valid stays high with stable (5,3,0x42); no fast_start until the handshake; corner_count=1 after frame_done.
4. Only 7 rows supplied -> after finishing row 3 the FSM waits in WAIT_ROW with no fast_start; an 8th row_ready resumes at (3,4).
5. Assert rst while in WAIT_FAST -> the next cycle has all outputs 0 and busy=0; a following frame_start restarts at (3,3); frame_start asserted mid-frame is ignored.
6. Spurious fast_done in ISSUE or WAIT_ROW -> no state change, no corner emitted.
